// File: rtl/spi_recv_con.sv
// rtl/spi_recv_con.sv - multi-line SPI receiver: synchronizes the sender's pins, assembles words, flags framing errors.
module spi_recv_con #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int COUNT_WIDTH = 18
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   chip_clk_in,
    input  logic                   chip_sel_in,
    input  logic [LINES-1:0]       chip_data_in,
    input  logic                   final_pixel_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid_out,
    output logic                   final_pixel_out,
    output logic [COUNT_WIDTH-1:0] pixel_index_out,
    output logic                   frame_err_out
);

    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    logic [1:0]       sclk_q, sclk_d;
    logic             sclk_hist_q, sclk_hist_d;
    logic [1:0]       scs_q, scs_d;
    logic             scs_hist_q, scs_hist_d;
    logic [LINES-1:0] sdat1_q, sdat1_d, sdat2_q, sdat2_d;
    logic [1:0]       sfin_q, sfin_d;

    state_t                state_q;
    logic [BW-1:0]         beat_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  done_q, err_q, fin_cap_q;

    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   final_q, final_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;

    logic                  edge_det, cs_low, cs_fall, take, last_beat;
    logic [DATA_WIDTH-1:0] shift_next;

    always_comb begin
        sclk_d      = {sclk_q[0], chip_clk_in};
        sclk_hist_d = sclk_q[1];
        scs_d       = {scs_q[0], chip_sel_in};
        scs_hist_d  = scs_q[1];
        sdat1_d     = chip_data_in;
        sdat2_d     = sdat1_q;
        sfin_d      = {sfin_q[0], final_pixel_in};

        edge_det   = sclk_q[1] & ~sclk_hist_q;
        cs_low     = ~scs_q[1];
        // The cs history resets to 0, so a select already low at reset release never looks like a fall.
        cs_fall    = ~scs_q[1] & scs_hist_q;
        take       = edge_det & cs_low & (((state_q == IDLE) & cs_fall) | (state_q == SHIFT));
        last_beat  = (int'(beat_q) == BEATS - 1);
        shift_next = (shift_q << LINES) | DATA_WIDTH'(sdat2_q);

        data_d  = done_q ? shift_q : data_q;
        valid_d = done_q;
        final_d = done_q & fin_cap_q;
        idx_d   = idx_q;
        if (valid_q) begin
            idx_d = final_q ? '0 : idx_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sclk_q      <= '0;
            sclk_hist_q <= 1'b0;
            scs_q       <= '0;
            scs_hist_q  <= 1'b0;
            sdat1_q     <= '0;
            sdat2_q     <= '0;
            sfin_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            final_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            sclk_q      <= sclk_d;
            sclk_hist_q <= sclk_hist_d;
            scs_q       <= scs_d;
            scs_hist_q  <= scs_hist_d;
            sdat1_q     <= sdat1_d;
            sdat2_q     <= sdat2_d;
            sfin_q      <= sfin_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            final_q     <= final_d;
            idx_q       <= idx_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fin_cap_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    if (cs_fall) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!cs_low) begin
                        err_q   <= 1'b1;
                        beat_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (!cs_low) state_q <= IDLE;
                    else if (edge_det) err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            // A beat taken in IDLE (edge coincident with the cs fall) counts as beat 0.
            if (take) begin
                shift_q <= shift_next;
                if (last_beat) begin
                    done_q    <= 1'b1;
                    fin_cap_q <= sfin_q[1];
                    beat_q    <= '0;
                    state_q   <= HOLD;
                end else begin
                    beat_q  <= beat_q + BW'(1);
                    state_q <= SHIFT;
                end
            end
        end
    end

    assign data_out        = data_q;
    assign data_valid_out  = valid_q;
    assign final_pixel_out = final_q;
    assign pixel_index_out = idx_q;
    assign frame_err_out   = err_q;

endmodule

// File: tb/tb_spi_recv_con.sv
// tb/tb_spi_recv_con.sv - directed bench for spi_recv_con with a word-level expectation queue.
module tb_spi_recv_con;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int CW = 18;
    localparam int BEATS = DW / L;

    logic          clk = 1'b0;
    logic          rst, cclk, cs, fin;
    logic [L-1:0]  cdat;
    logic [DW-1:0] data_out;
    logic          data_valid_out, final_pixel_out, frame_err_out;
    logic [CW-1:0] pixel_index_out;

    spi_recv_con #(.DATA_WIDTH(DW), .LINES(L), .COUNT_WIDTH(CW)) dut (
        .clk_in(clk), .rst_in(rst), .chip_clk_in(cclk), .chip_sel_in(cs),
        .chip_data_in(cdat), .final_pixel_in(fin), .data_out(data_out),
        .data_valid_out(data_valid_out), .final_pixel_out(final_pixel_out),
        .pixel_index_out(pixel_index_out), .frame_err_out(frame_err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          f;
        int            idx;
        int            at;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    logic [DW-1:0] got_d[$];
    int            got_i[$];
    logic          got_f[$];
    int            total = 0;
    int            bad = 0;
    int            err_seen = 0;
    int            err_exp = 0;
    int            m_idx = 0;
    logic [DW-1:0] hold_d = '0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle comparison against the word-level expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid_out) begin
                got_d.push_back(data_out);
                got_i.push_back(int'(pixel_index_out));
                got_f.push_back(final_pixel_out);
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", data_out, e.d);
                    chk("final", final_pixel_out, e.f);
                    chk("index", pixel_index_out, e.idx);
                    chk("latency", cyc, e.at);
                    hold_d = e.d;
                end
            end else begin
                chk("final_idle", final_pixel_out, 0);
                chk("data_hold", data_out, hold_d);
                if (q.size() > 0 && cyc > q[0].at) begin
                    chk("missing_valid", 0, 1);
                    void'(q.pop_front());
                end
            end
            if (frame_err_out) err_seen++;
        end
    end

    function automatic logic [L-1:0] beat_of(input logic [DW-1:0] w, input int b);
        logic [DW-1:0] t;
        if (b >= BEATS) return L'(b * 3 + 1);
        t = w >> (DW - L * (b + 1));
        return t[L-1:0];
    endfunction

    task automatic send(input logic [DW-1:0] w, input logic f, input int nb,
                        input int lo, input int hi, input int pre);
        exp_t x;
        cdat = beat_of(w, 0);
        fin  = f && (BEATS == 1);
        @(negedge clk);
        cs = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                cdat = beat_of(w, b);
                fin  = f && (b == BEATS - 1);
                repeat (lo) @(negedge clk);
            end else begin
                repeat (pre) @(negedge clk);
            end
            cclk = 1'b1;
            if (b == BEATS - 1) begin
                x.d = w; x.f = f; x.idx = m_idx; x.at = cyc + 4;
                q.push_back(x);
                m_idx = f ? 0 : (m_idx + 1) % (1 << CW);
            end
            if (b >= BEATS) err_exp++;
            repeat (hi) @(negedge clk);
            cclk = 1'b0;
        end
        if (nb < BEATS) err_exp++;
        repeat (3) @(negedge clk);
        cs  = 1'b1;
        fin = 1'b0;
        repeat (8) @(negedge clk);
        chk("err_count", err_seen, err_exp);
    endtask

    task automatic reset_checks();
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid_out, 0);
        chk("rst_final", final_pixel_out, 0);
        chk("rst_index", pixel_index_out, 0);
        chk("rst_err", frame_err_out, 0);
    endtask

    initial begin
        rst = 1'b1; cclk = 1'b0; cs = 1'b1; cdat = '0; fin = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Three-word frame, then the next word restarts at index 0.
        send(8'h01, 1'b0, 2, 6, 6, 4);
        send(8'h02, 1'b0, 2, 6, 6, 4);
        send(8'h03, 1'b1, 2, 6, 6, 4);
        chk("lit_idx2", got_i[$], 2);
        chk("lit_fin_03", got_f[$], 1);
        chk("lit_fin_01", got_f[0], 0);
        send(8'hA5, 1'b0, 2, 6, 6, 4);
        chk("lit_a5_data", got_d[$], 8'hA5);
        chk("lit_a5_idx", got_i[$], 0);
        chk("lit_valid_count", got_d.size(), 4);

        // Aborted after one beat, then a clean word.
        send(8'hEE, 1'b0, 1, 6, 6, 4);
        chk("lit_abort_no_valid", got_d.size(), 4);
        send(8'h3C, 1'b0, 2, 6, 6, 4);
        chk("lit_3c_data", got_d[$], 8'h3C);
        chk("lit_3c_idx", got_i[$], 1);

        // Extra edge in HOLD must not disturb the stored word.
        send(8'hC3, 1'b0, 3, 6, 6, 4);
        chk("lit_c3_hold", data_out, 8'hC3);

        // First edge coincident with the cs fall.
        send(8'h96, 1'b0, 2, 6, 6, 0);
        chk("lit_96_data", got_d[$], 8'h96);

        // Minimum 3/3 phase timing.
        for (int i = 1; i <= 4; i++) send(DW'(i * 8'h27), 1'b0, 2, 3, 3, 3);
        chk("lit_fast_last", got_d[$], 8'h9C);

        // Chip-clock edges with cs high are silently ignored.
        for (int i = 0; i < 3; i++) begin
            repeat (6) @(negedge clk); cclk = 1'b1;
            repeat (6) @(negedge clk); cclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("cs_high_err", err_seen, err_exp);

        // Reset between beat 0 and beat 1, cs held low afterwards.
        cdat = 4'h9;
        @(negedge clk); cs = 1'b0;
        repeat (4) @(negedge clk); cclk = 1'b1;
        repeat (6) @(negedge clk); cclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete(); hold_d = '0; m_idx = 0;
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cdat = L'(i + 5);
            repeat (6) @(negedge clk); cclk = 1'b1;
            repeat (6) @(negedge clk); cclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("post_rst_err", err_seen, err_exp);
        chk("post_rst_data", data_out, 0);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        send(8'h5A, 1'b0, 2, 6, 6, 4);
        chk("lit_5a_data", got_d[$], 8'h5A);
        chk("lit_5a_idx", got_i[$], 0);

        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("err_final", err_seen, err_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_recv_con.md
SPI_RECV_CON -- requirements
Module: spi_recv_con

Interface
REQ-001 Parameter DATA_WIDTH, default 8; bits per received word.
REQ-002 Parameter LINES, default 4; parallel data lines per beat. DATA_WIDTH SHALL be an integer multiple of LINES, with BEATS = DATA_WIDTH/LINES.
REQ-003 Parameter COUNT_WIDTH, default 18; width of the pixel index counter.
REQ-004 clk_in  input  1  system clock; all logic is on its rising edge.
REQ-005 rst_in  input  1  reset; asynchronous, active-high.
REQ-006 chip_clk_in  input  1  SPI data clock from the sender; asynchronous to clk_in.
REQ-007 chip_sel_in  input  1  chip select; active-low.
REQ-008 chip_data_in  input  LINES  parallel data lines.
REQ-009 final_pixel_in  input  1  sender's last-pixel flag; valid with the final beat.
REQ-010 data_out  output  DATA_WIDTH  assembled word.
REQ-011 data_valid_out  output  1  one-cycle pulse; data_out is valid.
REQ-012 final_pixel_out  output  1  asserted with data_valid_out when the word carried the final flag.
REQ-013 pixel_index_out  output  COUNT_WIDTH  index of the word on data_out within the current frame.
REQ-014 frame_err_out  output  1  one-cycle pulse on a malformed transaction.

Function
REQ-015 The block SHALL pass chip_clk_in, chip_sel_in, chip_data_in and final_pixel_in each through a 2-flop synchronizer, plus one history flop on the chip clock.
REQ-016 A chip-clock rising edge SHALL be detected when the synchronized clock is 1 and its history flop is 0.
REQ-017 Each detected edge while synchronized chip_sel is 0 SHALL capture one beat of synchronized chip_data_in.
REQ-018 Beats SHALL be MSB-first: beat 0 fills data bits [DATA_WIDTH-1 -: LINES]. Within each beat, chip_data_in[LINES-1] is the most significant bit.
REQ-019 Input timing: the chip clock SHALL stay high for at least 3 clk_in cycles and low for at least 3 clk_in cycles. Data SHALL be stable from 1 cycle before to 3 cycles after each chip-clock rise.
REQ-020 The FSM SHALL have three states: IDLE, SHIFT and HOLD.
- IDLE: beat counter = 0. Go to SHIFT when synchronized chip_sel falls.
- SHIFT: capture beats. On beat BEATS-1, pulse data_valid_out and go to HOLD.
- HOLD: ignore further edges. Go to IDLE when synchronized chip_sel rises.
REQ-021 Latency: data_valid_out SHALL assert exactly 3 clk_in cycles after the first clk_in edge that samples chip_clk_in high for the last beat.
REQ-022 data_out SHALL hold its value until the next valid word.
REQ-023 final_pixel_out SHALL equal the synchronized final_pixel_in captured with the last beat, and SHALL be 0 whenever data_valid_out is 0.
REQ-024 pixel_index_out SHALL increment by 1 on the cycle after each valid word.
- After a word with the final flag, it SHALL become 0.
- On counter overflow it SHALL wrap to 0 with no error.
REQ-025 If chip_sel rises in SHIFT with fewer than BEATS beats captured:
- the partial word SHALL be discarded with no data_valid_out;
- frame_err_out SHALL pulse for one cycle;
- the FSM SHALL return to IDLE.
REQ-026 A chip-clock edge in HOLD SHALL pulse frame_err_out and SHALL NOT alter data_out.
REQ-027 A chip-clock edge detected on the same cycle that chip_sel falls SHALL be captured as beat 0.
REQ-028 Edges while chip_sel is high SHALL be ignored silently.

Reset
REQ-029 While rst_in is high, the block SHALL hold:
- FSM = IDLE and beat counter = 0;
- data_out = 0, data_valid_out = 0, final_pixel_out = 0;
- pixel_index_out = 0, frame_err_out = 0;
- all synchronizer and history flops = 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction without a valid or error pulse.
REQ-031 After reset release, a transaction already in progress (chip_sel low) SHALL be ignored until chip_sel has been seen high.

Verification
REQ-032 Defaults, chip clock period 12 clk_in cycles, cs low, beats 0xA then 0x5 -> exactly one data_valid_out with data_out=0xA5 and pixel_index_out=0.
REQ-033 Three words 0x01, 0x02, 0x03, with the final flag on the third -> indices 0, 1, 2. final_pixel_out pulses only with 0x03. The next word gets index 0.
REQ-034 cs raised after one beat -> frame_err_out pulses once, no data_valid_out. A following word 0x3C is received correctly.
REQ-035 Third chip-clock edge within one cs window -> frame_err_out pulse, data_out stays at the first word.
REQ-036 rst_in pulsed between beats 0 and 1 -> no valid or error pulse, all outputs 0. With cs held low afterwards, nothing is received until cs goes high and then low again.
REQ-037 Chip clock with 3-cycle high and 3-cycle low phases -> every word decoded. Latency checked at 3 cycles per REQ-021.
